ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Gated frequency meter sitting directly upstream of the averaging stage.
- Takes the selected ring-oscillator output, which is asynchronous to the system clock, and synchronises it.
- Counts its rising edges over a programmable window of clk cycles.
- Presents each window's edge count with a one-cycle valid strobe, plus a saturation flag, for the averager to consume.

Parameters:
- COUNT_W, 16, width of the edge-count result.
- WIN_W, 16, width of the window-length input and window counter.
- SYNC_STAGES, 2, number of synchroniser flops on osc_in (minimum 2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- osc_in  in  1  ring-oscillator output, asynchronous to clk.
- en  in  1  block enable; low aborts any measurement.
- start  in  1  single-cycle request to begin a window; sampled only in IDLE.
- auto_rearm  in  1  when high, a new window starts immediately after each completed one.
- win_len  in  WIN_W  window length in clk cycles; latched when a window starts.
- count  out  COUNT_W  edge count of the last completed window.
- count_valid  out  1  one-cycle pulse when count is updated.
- overflow  out  1  the last completed window saturated; updated with count.
- busy  out  1  high while in MEASURE.

Behaviour:
- Reset (async, rst_n=0) clears: synchroniser flops, edge-detect flop, state (IDLE), window counter, edge accumulator, count, count_valid, overflow, busy. All outputs read 0.
- Sampling path:
  - osc_in passes through SYNC_STAGES flops, then one delay flop.
  - edge_pulse = sync_last & ~delay.
  - Latency from the osc rising edge to edge_pulse is SYNC_STAGES+1 clk cycles.
  - The measurable frequency is therefore at most clk/2; higher frequencies alias and this is not detected.
- States: IDLE, MEASURE. busy = (state==MEASURE).
- IDLE -> MEASURE:
  - Condition: en=1 and start=1.
  - On that cycle: latch win_len, clear window counter and accumulator.
- In MEASURE:
  - The window spans exactly N = latched win_len cycles, starting the cycle after the transition.
  - The accumulator adds edge_pulse every window cycle.
  - The accumulator saturates at all-ones and sets a sticky sat bit; it never wraps.
- End of window (cycle N):
  - Next cycle: count <= accumulator (including the final cycle's pulse), overflow <= sat, count_valid=1 for one cycle.
  - Then, if auto_rearm=1 and en=1: stay in MEASURE, relatch win_len, clear accumulator and sat. This gives a gapless back-to-back window; count_valid and the new window's first cycle coincide.
  - Otherwise: go to IDLE.
- win_len=0 is treated as 1. No zero-length window exists.
- start while busy is ignored. start with en=0 is ignored.
- en falling during MEASURE:
  - Go to IDLE next cycle.
  - The window is discarded: no count_valid; count and overflow hold their previous values.
- count and overflow hold between windows. Consumers sample only on count_valid.
- Asynchronous reset mid-window aborts immediately. No valid is emitted after release.
- Synchroniser flops run regardless of en, so there is no false edge when a window starts.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, MEASURE);
  - default COUNT_W and WIN_W, so the averager and top agree on count width.
- One natural sub-module: ro_sync_edge. It contains the parameterised synchroniser plus the rising-edge detector. Its outputs are edge_pulse and the synchronised level. It is reused for the external clock select and any other async inputs.

Test Plan:
- osc_in square wave, period 4 clk; win_len=100; single start -> count_valid once, 100+1 cycles after start, with count=25, overflow=0, busy high for exactly 100 cycles.
- Override COUNT_W=8; osc_in period 2 clk; win_len=600 -> count=255, overflow=1. Next window with osc_in held 0, win_len=10 -> count=0, overflow=0.
- auto_rearm=1; osc period 8; win_len=64 -> count_valid every 64 cycles with no gap, count=8 each time; busy never drops.
- Start a window, drop en at cycle 30 of 100 -> busy low next cycle, no count_valid, count still holds the prior value; start while busy is ignored (the window end does not shift).
- Assert rst_n=0 asynchronously mid-window -> all outputs 0 immediately. After release with osc_in held high, start a window of win_len=0 -> treated as 1, count=0, no spurious edge.
- Sweep osc_in at a random phase vs clk, period 6.3 clk, win_len=1000 -> count within 158 or 159; never more than floor(1000/2).

Source files
------------

// File: rtl/ro_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter and its downstream averager.
package ro_freq_meter_pkg;

  localparam int COUNT_W_DEF     = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_e;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Control/result bundle between the meter and its controller/averager.
interface ro_freq_meter_if
  import ro_freq_meter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int WIN_W   = WIN_W_DEF
);

  logic               en;
  logic               start;
  logic               auto_rearm;
  logic [WIN_W-1:0]   win_len;
  logic [COUNT_W-1:0] count;
  logic               count_valid;
  logic               overflow;
  logic               busy;

  modport master (
    output en, start, auto_rearm, win_len,
    input  count, count_valid, overflow, busy
  );

  modport slave (
    input  en, start, auto_rearm, win_len,
    output count, count_valid, overflow, busy
  );

endinterface

// File: rtl/ro_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse.
module ro_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              delay_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      delay_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~delay_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated edge counter: counts synchronised osc_in rising edges over a window of clk cycles.
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            osc_in,
  ro_freq_meter_if.slave  bus
);

  logic edge_pulse;
  logic osc_level_unused;

  ro_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_in),
    .level_o (osc_level_unused),
    .rise_o  (edge_pulse)
  );

  meter_state_e       state_q;
  logic [WIN_W-1:0]   win_len_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [COUNT_W-1:0] acc_q;
  logic               sat_q;
  logic [COUNT_W-1:0] count_q;
  logic               count_valid_q;
  logic               overflow_q;
  logic               busy_q;

  logic [WIN_W-1:0]   win_eff;
  logic               acc_full;
  logic [COUNT_W-1:0] acc_d;
  logic               sat_d;
  logic               win_last;

  // A zero-length request still measures one cycle.
  assign win_eff  = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  assign acc_full = &acc_q;
  assign acc_d    = (edge_pulse && !acc_full) ? acc_q + COUNT_W'(1) : acc_q;
  assign sat_d    = sat_q | (edge_pulse & acc_full);
  assign win_last = (win_cnt_q == win_len_q - WIN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      win_len_q     <= '0;
      win_cnt_q     <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.en && bus.start) begin
            state_q   <= ST_MEASURE;
            busy_q    <= 1'b1;
            win_len_q <= win_eff;
            win_cnt_q <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (!bus.en) begin
            // Abandoned window: results keep their previous values.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (win_last) begin
            count_q       <= acc_d;
            overflow_q    <= sat_d;
            count_valid_q <= 1'b1;
            if (bus.auto_rearm) begin
              win_len_q <= win_eff;
              win_cnt_q <= '0;
              acc_q     <= '0;
              sat_q     <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            acc_q     <= acc_d;
            sat_q     <= sat_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed self-checking bench for ro_freq_meter (16-bit and 8-bit count instances).
module tb_ro_freq_meter;
  import ro_freq_meter_pkg::*;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic osc_in    = 1'b0;
  logic osc_run   = 1'b0;
  logic osc_level = 1'b0;
  int   osc_half  = 20;

  int n_checks = 0;
  int n_fail   = 0;

  ro_freq_meter_if #(.COUNT_W(16), .WIN_W(16)) m16 ();
  ro_freq_meter_if #(.COUNT_W(8),  .WIN_W(16)) m8 ();

  ro_freq_meter #(.COUNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .bus(m16)
  );

  ro_freq_meter #(.COUNT_W(8), .WIN_W(16), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .bus(m8)
  );

  // clk period is 20 time units
  always #10 clk = ~clk;

  always begin
    if (osc_run) begin
      #(osc_half);
      osc_in = ~osc_in;
    end else begin
      osc_in = osc_level;
      #1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Restart the oscillator in phase with the falling clk edge, half period in time units.
  task automatic osc_sync(input int half);
    osc_run   = 1'b0;
    osc_level = 1'b0;
    repeat (8) @(negedge clk);
    osc_half = half;
    osc_run  = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // lat = negedges from the start cycle until count_valid is seen (budget on expiry).
  task automatic run16(input int wl, input int stray_at, input int budget,
                       output int lat, output logic [15:0] cnt, output logic ovf,
                       output int busy_cycles);
    @(negedge clk);
    m16.win_len = 16'(wl);
    m16.start   = 1'b1;
    lat = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      m16.start = (lat == stray_at) ? 1'b1 : 1'b0;
      if (lat == stray_at) m16.win_len = 16'd20;
      if (m16.busy) busy_cycles++;
    end while (!m16.count_valid && lat < budget);
    m16.start = 1'b0;
    if (m16.busy) busy_cycles--;
    cnt = m16.count;
    ovf = m16.overflow;
    $display("window16 win_len=%0d latency=%0d count=%0d overflow=%0b busy_cycles=%0d",
             wl, lat, cnt, ovf, busy_cycles);
  endtask

  task automatic run8(input int wl, input int budget,
                      output int lat, output logic [7:0] cnt, output logic ovf);
    @(negedge clk);
    m8.win_len = 16'(wl);
    m8.start   = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      m8.start = 1'b0;
    end while (!m8.count_valid && lat < budget);
    cnt = m8.count;
    ovf = m8.overflow;
    $display("window8 win_len=%0d latency=%0d count=%0d overflow=%0b", wl, lat, cnt, ovf);
  endtask

  initial begin
    int          lat;
    int          bc;
    int          seen;
    int          nlow;
    int          nval;
    int          v1;
    int          v2;
    logic [15:0] cnt16;
    logic [7:0]  cnt8;
    logic        ovf;

    m16.en = 1'b0; m16.start = 1'b0; m16.auto_rearm = 1'b0; m16.win_len = '0;
    m8.en  = 1'b0; m8.start  = 1'b0; m8.auto_rearm  = 1'b0; m8.win_len  = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_count", m16.count, 0);
    check_eq("rst_valid", m16.count_valid, 0);
    check_eq("rst_overflow", m16.overflow, 0);
    check_eq("rst_busy", m16.busy, 0);
    check_eq("rst_count8", m8.count, 0);
    rst_n  = 1'b1;
    m16.en = 1'b1;

    // Period 4, window 100: exactly 25 edges.
    osc_sync(40);
    run16(100, 0, 300, lat, cnt16, ovf, bc);
    check_eq("t1_latency", lat, 101);
    check_eq("t1_count", cnt16, 25);
    check_eq("t1_overflow", ovf, 0);
    check_eq("t1_busy_cycles", bc, 100);
    check_eq("t1_busy_at_valid", m16.busy, 0);
    @(negedge clk);
    check_eq("t1_valid_one_cycle", m16.count_valid, 0);
    check_eq("t1_count_hold", m16.count, 25);

    // Period 8, window 96 with a stray start mid-window: end must not move.
    osc_sync(80);
    run16(96, 10, 300, lat, cnt16, ovf, bc);
    check_eq("busy_start_latency", lat, 97);
    check_eq("busy_start_count", cnt16, 12);
    check_eq("busy_start_busy_cycles", bc, 96);

    // Abort by dropping en at cycle 30.
    osc_sync(40);
    @(negedge clk);
    m16.win_len = 16'd100;
    m16.start   = 1'b1;
    @(negedge clk);
    m16.start = 1'b0;
    repeat (29) @(negedge clk);
    check_eq("abort_busy_before", m16.busy, 1);
    m16.en = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_after", m16.busy, 0);
    seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (m16.count_valid) seen++;
    end
    check_eq("abort_no_valid", seen, 0);
    check_eq("abort_count_hold", m16.count, 12);
    check_eq("abort_overflow_hold", m16.overflow, 0);
    $display("abort window: valids=%0d count=%0d", seen, m16.count);
    m16.en = 1'b1;

    // Back-to-back windows: period 8, window 64.
    osc_sync(80);
    m16.auto_rearm = 1'b1;
    @(negedge clk);
    m16.win_len = 16'd64;
    m16.start   = 1'b1;
    nlow = 0; nval = 0; v1 = 0; v2 = 0;
    for (int c = 1; c <= 192; c++) begin
      @(negedge clk);
      m16.start = 1'b0;
      if (!m16.busy) nlow++;
      if (m16.count_valid) begin
        nval++;
        if (nval == 1) v1 = c;
        if (nval == 2) v2 = c;
        check_eq("rearm_count", m16.count, 8);
        $display("rearm window at cycle %0d count=%0d", c, m16.count);
      end
      if (c == 192) m16.auto_rearm = 1'b0;
    end
    check_eq("rearm_first_valid", v1, 65);
    check_eq("rearm_second_valid", v2, 129);
    check_eq("rearm_valid_count", nval, 2);
    check_eq("rearm_busy_gaps", nlow, 0);
    @(negedge clk);
    check_eq("rearm_last_valid", m16.count_valid, 1);
    check_eq("rearm_last_count", m16.count, 8);
    check_eq("rearm_last_busy", m16.busy, 0);

    // 8-bit instance: saturation, then a clean zero window.
    osc_sync(20);
    m8.en = 1'b1;
    run8(600, 800, lat, cnt8, ovf);
    check_eq("sat_latency", lat, 601);
    check_eq("sat_count", cnt8, 255);
    check_eq("sat_overflow", ovf, 1);
    osc_run   = 1'b0;
    osc_level = 1'b0;
    repeat (8) @(negedge clk);
    run8(10, 50, lat, cnt8, ovf);
    check_eq("zero_latency", lat, 11);
    check_eq("zero_count", cnt8, 0);
    check_eq("zero_overflow", ovf, 0);
    m8.en = 1'b0;

    // Asynchronous reset in the middle of a window.
    osc_sync(40);
    @(negedge clk);
    m16.win_len = 16'd100;
    m16.start   = 1'b1;
    @(negedge clk);
    m16.start = 1'b0;
    repeat (39) @(negedge clk);
    check_eq("areset_busy_before", m16.busy, 1);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    osc_run   = 1'b0;
    osc_level = 1'b1;
    #1;
    check_eq("areset_count", m16.count, 0);
    check_eq("areset_valid", m16.count_valid, 0);
    check_eq("areset_overflow", m16.overflow, 0);
    check_eq("areset_busy", m16.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (m16.count_valid) seen++;
    end
    check_eq("areset_no_valid", seen, 0);
    run16(0, 0, 20, lat, cnt16, ovf, bc);
    check_eq("winlen0_latency", lat, 2);
    check_eq("winlen0_count", cnt16, 0);
    check_eq("winlen0_busy_cycles", bc, 1);

    // Free-running period 6.3 clk at a random phase, window 1000.
    osc_run   = 1'b0;
    osc_level = 1'b0;
    repeat (8) @(negedge clk);
    #($urandom_range(0, 125));
    osc_half = 63;
    osc_run  = 1'b1;
    repeat (10) @(negedge clk);
    run16(1000, 0, 1100, lat, cnt16, ovf, bc);
    check_eq("sweep_latency", lat, 1001);
    check_eq("sweep_count_range", (cnt16 >= 16'd158 && cnt16 <= 16'd159), 1);
    check_eq("sweep_count_limit", (cnt16 <= 16'd500), 1);
    check_eq("sweep_overflow", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
